// File: rtl/fmul_pkg.sv
// Shared constants and payload types for the binary32 multiply back end.
// Holds operand class codes, flag bit positions and the normalised stage payload.
package fmul_pkg;

  localparam int unsigned FRAC_W = 48;
  localparam int unsigned EXP_W  = 10;
  localparam int unsigned MANT_W = 23;
  localparam int unsigned SUM_W  = MANT_W + 1;
  localparam int unsigned RSLT_W = 32;
  localparam int unsigned FLAG_W = 5;

  localparam logic [1:0] SPC_NORM = 2'b00;
  localparam logic [1:0] SPC_ZERO = 2'b01;
  localparam logic [1:0] SPC_INF  = 2'b10;
  localparam logic [1:0] SPC_NAN  = 2'b11;

  localparam int unsigned FLG_NV = 4;
  localparam int unsigned FLG_DZ = 3;
  localparam int unsigned FLG_OF = 2;
  localparam int unsigned FLG_UF = 1;
  localparam int unsigned FLG_NX = 0;

  localparam logic [RSLT_W-1:0] CANON_NAN = 32'h7FC0_0000;
  localparam int                EXP_MAX   = 255;

  // Product after the single-position normalise, ahead of rounding.
  typedef struct packed {
    logic              sgn;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              lsb;
    logic              grd;
    logic              stk;
    logic [1:0]        spc;
    logic              nv;
  } norm_t;

  function automatic logic [RSLT_W-1:0] pack_fp(input logic sgn, input logic [7:0] e,
                                                input logic [MANT_W-1:0] m);
    return {sgn, e, m};
  endfunction

endpackage

// File: rtl/fmul_rnd_pack.sv
// Round-to-nearest-even, exception selection and binary32 packing.
// Purely combinational so it can sit behind any pipeline register.
module fmul_rnd_pack
  import fmul_pkg::*;
(
  input  norm_t               i_norm,
  output logic [RSLT_W-1:0]   o_rslt_c,
  output logic [FLAG_W-1:0]   o_flag_c
);

  logic                    w_rnd;
  logic [SUM_W-1:0]        w_sum;
  logic                    w_carry;
  logic [MANT_W-1:0]       w_mant;
  logic signed [EXP_W:0]   w_exp;
  logic                    w_nx;
  logic                    w_of;
  logic                    w_uf;

  assign w_rnd   = i_norm.grd & (i_norm.stk | i_norm.lsb);
  assign w_sum   = {1'b0, i_norm.mant} + SUM_W'(w_rnd);
  assign w_carry = w_sum[MANT_W];
  assign w_mant  = w_carry ? '0 : w_sum[MANT_W-1:0];
  assign w_nx    = i_norm.grd | i_norm.stk;

  // One guard bit of headroom keeps the carry-in bump from wrapping the sign.
  assign w_exp = $signed({i_norm.exp[EXP_W-1], i_norm.exp})
               + $signed({{EXP_W{1'b0}}, w_carry});
  assign w_of  = int'(w_exp) >= EXP_MAX;
  assign w_uf  = int'(w_exp) <= 0;

  always_comb begin
    o_rslt_c         = pack_fp(i_norm.sgn, w_exp[7:0], w_mant);
    o_flag_c         = '0;
    o_flag_c[FLG_NX] = w_nx;
    if ((i_norm.spc == SPC_NAN) || i_norm.nv) begin
      o_rslt_c         = CANON_NAN;
      o_flag_c         = '0;
      o_flag_c[FLG_NV] = i_norm.nv;
    end else if (i_norm.spc == SPC_INF) begin
      o_rslt_c = pack_fp(i_norm.sgn, 8'hFF, '0);
      o_flag_c = '0;
    end else if (i_norm.spc == SPC_ZERO) begin
      o_rslt_c = pack_fp(i_norm.sgn, 8'h00, '0);
      o_flag_c = '0;
    end else if (w_of) begin
      o_rslt_c         = pack_fp(i_norm.sgn, 8'hFF, '0);
      o_flag_c         = '0;
      o_flag_c[FLG_OF] = 1'b1;
      o_flag_c[FLG_NX] = 1'b1;
    end else if (w_uf) begin
      o_rslt_c         = pack_fp(i_norm.sgn, 8'h00, '0);
      o_flag_c         = '0;
      o_flag_c[FLG_UF] = 1'b1;
      o_flag_c[FLG_NX] = 1'b1;
    end
  end

endmodule

// File: rtl/fmul_rnd.sv
// Two-stage normalise / round-and-pack pipeline behind the multiplier array.
// Stage 1 registers the normalised product, stage 2 registers the packed result.
module fmul_rnd
  import fmul_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sgn,
  input  logic [EXP_W-1:0]    in_exp,
  input  logic [FRAC_W-1:0]   in_frac,
  input  logic [1:0]          in_spc,
  input  logic                in_nv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RSLT_W-1:0]   rslt,
  output logic [FLAG_W-1:0]   flag
);

  logic                r_v1;
  logic                r_v2;
  norm_t               r_s1;
  logic [RSLT_W-1:0]   r_rslt;
  logic [FLAG_W-1:0]   r_flag;

  norm_t               w_norm;
  logic                w_adv1;
  logic                w_adv2;
  logic [RSLT_W-1:0]   w_rslt_c;
  logic [FLAG_W-1:0]   w_flag_c;

  assign w_adv2 = !r_v2 | out_ready;
  assign w_adv1 = !r_v1 | w_adv2;

  // Product lies in [1,4): shift by one when the top bit is set.
  always_comb begin
    w_norm     = '0;
    w_norm.sgn = in_sgn;
    w_norm.spc = in_spc;
    w_norm.nv  = in_nv;
    if (in_frac[FRAC_W-1]) begin
      w_norm.mant = in_frac[46:24];
      w_norm.lsb  = in_frac[24];
      w_norm.grd  = in_frac[23];
      w_norm.stk  = |in_frac[22:0];
      w_norm.exp  = in_exp + EXP_W'(1);
    end else begin
      w_norm.mant = in_frac[45:23];
      w_norm.lsb  = in_frac[23];
      w_norm.grd  = in_frac[22];
      w_norm.stk  = |in_frac[21:0];
      w_norm.exp  = in_exp;
    end
  end

  fmul_rnd_pack u_pack (
    .i_norm   (r_s1),
    .o_rslt_c (w_rslt_c),
    .o_flag_c (w_flag_c)
  );

  // Valid bits and the visible result clear on reset; result loads only with a real beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_rslt <= '0;
      r_flag <= '0;
    end else begin
      if (w_adv1) r_v1 <= in_valid;
      if (w_adv2) r_v2 <= r_v1;
      if (w_adv2 && r_v1) begin
        r_rslt <= w_rslt_c;
        r_flag <= w_flag_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv1 && in_valid) r_s1 <= w_norm;
  end

  assign in_ready  = w_adv1;
  assign out_valid = r_v2;
  assign rslt      = r_rslt;
  assign flag      = r_flag;

endmodule

// File: tb/tb_fmul_rnd.sv
// Scoreboard bench for fmul_rnd: driver pushes model results, monitor pops on output transfer.
module tb_fmul_rnd;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sgn;
  logic [9:0]  in_exp;
  logic [47:0] in_frac;
  logic [1:0]  in_spc;
  logic        in_nv;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rslt;
  logic [4:0]  flag;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  f;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          errs  = 0;
  int          cyc   = 0;
  bit          saw_stall = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_r;
  logic [4:0]  prev_f;

  fmul_rnd dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sgn    (in_sgn),
    .in_exp    (in_exp),
    .in_frac   (in_frac),
    .in_spc    (in_spc),
    .in_nv     (in_nv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rslt      (rslt),
    .flag      (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer rounding of frac / 2^shift, then IEEE exception rules.
  function automatic logic [36:0] model(input logic sgn, input int e_in, input logic [47:0] frac,
                                        input logic [1:0] spc, input logic nv);
    longint unsigned f, q, rem, half;
    int sh, e;
    bit nx;
    if (spc == 2'b11 || nv) return {32'h7FC0_0000, nv, 4'b0000};
    if (spc == 2'b10) return {sgn, 8'hFF, 23'd0, 5'd0};
    if (spc == 2'b01) return {sgn, 31'd0, 5'd0};
    f    = longint'(frac);
    sh   = (f >= (64'd1 << 47)) ? 24 : 23;
    e    = e_in + ((sh == 24) ? 1 : 0);
    q    = f >> sh;
    rem  = f - (q << sh);
    half = 64'd1 << (sh - 1);
    nx   = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {sgn, 8'hFF, 23'd0, 5'b00101};
    if (e <= 0) return {sgn, 31'd0, 5'b00011};
    return {sgn, 8'(e), q[22:0], 4'b0000, nx};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Presents one beat, waits for acceptance, enqueues the model answer.
  task automatic send(input logic sgn, input int e, input logic [47:0] frac,
                      input logic [1:0] spc, input logic nv, input bit lat);
    exp_t x;
    logic [36:0] m;
    bit ok;
    ok       = 0;
    in_valid = 1'b1;
    in_sgn   = sgn;
    in_exp   = 10'(e);
    in_frac  = frac;
    in_spc   = spc;
    in_nv    = nv;
    m        = model(sgn, e, frac, spc, nv);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        x.r = m[36:5];
        x.f = m[4:0];
        x.cyc = cyc;
        x.lat = lat;
        sb.push_back(x);
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      tests++;
      errs++;
      $display("FAIL send_timeout: in_ready stayed 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    #1;
  endtask

  task automatic rnd_beat(output logic sgn, output int e, output logic [47:0] frac,
                          output logic [1:0] spc, output logic nv);
    sgn  = 1'($urandom);
    frac = {16'($urandom), $urandom};
    if (!frac[47]) frac[46] = 1'b1;
    if ($urandom_range(0, 3) == 0) frac[21:0] = '0;
    e    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 420)) - 60
                                       : int'($urandom_range(1, 253));
    spc  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
    nv   = ($urandom_range(0, 15) == 0);
  endtask

  // Monitor: compare on every transfer and check hold-stability under back-pressure.
  always @(negedge clk) begin
    exp_t x;
    if (!reset) begin
      prev_stall = 0;
    end else if (out_valid) begin
      if (prev_stall) begin
        chk("hold_rslt", 64'(rslt), 64'(prev_r));
        chk("hold_flag", 64'(flag), 64'(prev_f));
      end
      if (out_ready) begin
        prev_stall = 0;
        if (sb.size() == 0) begin
          tests++;
          errs++;
          $display("FAIL unexpected_out: got %h/%h expected no beat", rslt, flag);
        end else begin
          x = sb.pop_front();
          chk("rslt", 64'(rslt), 64'(x.r));
          chk("flag", 64'(flag), 64'(x.f));
          if (x.lat) chk("latency", 64'(cyc - x.cyc), 64'd2);
        end
      end else begin
        prev_stall = 1;
        prev_r = rslt;
        prev_f = flag;
      end
    end else begin
      if (prev_stall) chk("valid_dropped", 64'(out_valid), 64'd1);
      prev_stall = 0;
    end
    if (reset && in_valid && !in_ready) saw_stall = 1;
  end

  initial begin
    logic        s, nv;
    int          e;
    logic [47:0] f;
    logic [1:0]  sp;
    bit          done;

    reset = 1'b0; in_valid = 1'b0; in_sgn = 1'b0; in_exp = '0;
    in_frac = '0; in_spc = '0; in_nv = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_rslt", 64'(rslt), 64'd0);
    chk("rst_flag", 64'(flag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed corner cases; latency checked on each.
    send(1'b0, 127, 48'h9000_0000_0000, 2'b00, 1'b0, 1); drain();
    chk("dir_1p5_sq", 64'(model(1'b0, 127, 48'h9000_0000_0000, 2'b00, 1'b0)), 64'({32'h4010_0000, 5'h00}));
    send(1'b0, 127, 48'h4000_0040_0000, 2'b00, 1'b0, 1); drain();
    send(1'b0, 127, 48'h4000_00C0_0000, 2'b00, 1'b0, 1); drain();
    send(1'b0, 127, 48'h7FFF_FFC0_0000, 2'b00, 1'b0, 1); drain();
    send(1'b0, 254, 48'h8000_0000_0000, 2'b00, 1'b0, 1); drain();
    send(1'b1, 0,   48'h4000_0000_0000, 2'b00, 1'b0, 1); drain();
    send(1'b0, 127, 48'h1234_5678_9ABC, 2'b11, 1'b1, 1); drain();
    send(1'b1, 10,  48'h8000_0000_0000, 2'b10, 1'b0, 1); drain();
    send(1'b1, 10,  48'h8000_0000_0000, 2'b01, 1'b0, 1); drain();

    // Back-pressure: four back-to-back beats, output stalled for three cycles.
    saw_stall = 0;
    done = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          rnd_beat(s, e, f, sp, nv);
          send(s, e, f, sp, nv, 0);
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_in_ready_dropped", 64'(saw_stall), 64'd1);

    // Random traffic with random gaps and random back-pressure.
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          rnd_beat(s, e, f, sp, nv);
          send(s, e, f, sp, nv, 0);
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight: both discarded, nothing emitted later.
    out_ready = 1'b0;
    rnd_beat(s, e, f, sp, nv);
    send(s, e, f, 2'b00, 1'b0, 0);
    rnd_beat(s, e, f, sp, nv);
    send(s, e, f, 2'b00, 1'b0, 0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_rslt", 64'(rslt), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", 64'(in_ready), 64'd1);
    chk("postrst_valid", 64'(out_valid), 64'd0);
    chk("postrst_flag", 64'(flag), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("postrst_quiet", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
